// File: rtl/axi4_lite_arb2_if.sv
// AXI4-Lite bundle shared by the 2:1 arbiter and its neighbours.
// Master modport drives AW/W/AR and B/R ready; slave modport the reverse.
interface axi4_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              AWVALID;
  logic              AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;
  logic              WVALID;
  logic              WREADY;
  logic [DATA_W-1:0] WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic              BVALID;
  logic              BREADY;
  logic              BRESP;
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARPROT;
  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic              RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT,
    output WVALID, WDATA, WSTRB,
    output BREADY, ARVALID, ARADDR, ARPROT,
    output RREADY,
    input  AWREADY, WREADY, BVALID, BRESP,
    input  ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT,
    input  WVALID, WDATA, WSTRB,
    input  BREADY, ARVALID, ARADDR, ARPROT,
    input  RREADY,
    output AWREADY, WREADY, BVALID, BRESP,
    output ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi4_lite_arb2.sv
// 2:1 AXI4-Lite arbiter, one transaction in flight, round-robin owner.
// Ports: ACLK, ARESETn, s0/s1 (masters in), m (shared slave), grant, busy.
module axi4_lite_arb2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  axi4_lite_if.slave  s0,
  axi4_lite_if.slave  s1,
  axi4_lite_if.master m,
  output logic [1:0]  grant,
  output logic        busy
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE, WRITE, WRESP, READ, RDATA
  } state_e;

  state_e state_q, state_d;
  logic   g_q, g_d;
  logic   rr_q, rr_d;
  logic   last_wr_q, last_wr_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  // granted master's request side
  logic              g_awvalid;
  logic [ADDR_W-1:0] g_awaddr;
  logic [2:0]        g_awprot;
  logic              g_wvalid;
  logic [DATA_W-1:0] g_wdata;
  logic [STRB_W-1:0] g_wstrb;
  logic              g_bready;
  logic              g_arvalid;
  logic [ADDR_W-1:0] g_araddr;
  logic [2:0]        g_arprot;
  logic              g_rready;

  assign g_awvalid = g_q ? s1.AWVALID : s0.AWVALID;
  assign g_awaddr  = g_q ? s1.AWADDR  : s0.AWADDR;
  assign g_awprot  = g_q ? s1.AWPROT  : s0.AWPROT;
  assign g_wvalid  = g_q ? s1.WVALID  : s0.WVALID;
  assign g_wdata   = g_q ? s1.WDATA   : s0.WDATA;
  assign g_wstrb   = g_q ? s1.WSTRB   : s0.WSTRB;
  assign g_bready  = g_q ? s1.BREADY  : s0.BREADY;
  assign g_arvalid = g_q ? s1.ARVALID : s0.ARVALID;
  assign g_araddr  = g_q ? s1.ARADDR  : s0.ARADDR;
  assign g_arprot  = g_q ? s1.ARPROT  : s0.ARPROT;
  assign g_rready  = g_q ? s1.RREADY  : s0.RREADY;

  // response side before routing to the owner
  logic              o_awready;
  logic              o_wready;
  logic              o_bvalid;
  logic              o_bresp;
  logic              o_arready;
  logic              o_rvalid;
  logic [DATA_W-1:0] o_rdata;
  logic              o_rresp;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      g_q       <= 1'b0;
      rr_q      <= 1'b0;
      last_wr_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      rr_q      <= rr_d;
      last_wr_q <= last_wr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  logic req0, req1, win, win_aw, win_ar;

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    rr_d      = rr_q;
    last_wr_d = last_wr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    req0   = s0.AWVALID | s0.ARVALID;
    req1   = s1.AWVALID | s1.ARVALID;
    win    = (req0 & req1) ? rr_q : req1;
    win_aw = win ? s1.AWVALID : s0.AWVALID;
    win_ar = win ? s1.ARVALID : s0.ARVALID;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          g_d = win;
          // dual request alternates by last completed type
          if (win_aw & ~(win_ar & last_wr_q))
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      WRITE: begin
        aw_done_d = aw_done_q | (g_awvalid & m.AWREADY);
        w_done_d  = w_done_q | (g_wvalid & m.WREADY);
        if (aw_done_d & w_done_d) begin
          state_d   = WRESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WRESP: begin
        if (m.BVALID & g_bready) begin
          state_d   = IDLE;
          rr_d      = ~g_q;
          last_wr_d = 1'b1;
        end
      end
      READ: begin
        if (g_arvalid & m.ARREADY)
          state_d = RDATA;
      end
      RDATA: begin
        if (m.RVALID & g_rready) begin
          state_d   = IDLE;
          rr_d      = ~g_q;
          last_wr_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m.AWADDR = g_awaddr;
  assign m.AWPROT = g_awprot;
  assign m.WDATA  = g_wdata;
  assign m.WSTRB  = g_wstrb;
  assign m.ARADDR = g_araddr;
  assign m.ARPROT = g_arprot;

  always_comb begin
    m.AWVALID = 1'b0;
    m.WVALID  = 1'b0;
    m.BREADY  = 1'b0;
    m.ARVALID = 1'b0;
    m.RREADY  = 1'b0;
    o_awready = 1'b0;
    o_wready  = 1'b0;
    o_bvalid  = 1'b0;
    o_bresp   = 1'b0;
    o_arready = 1'b0;
    o_rvalid  = 1'b0;
    o_rdata   = '0;
    o_rresp   = 1'b0;
    unique case (state_q)
      WRITE: begin
        m.AWVALID = g_awvalid & ~aw_done_q;
        m.WVALID  = g_wvalid & ~w_done_q;
        o_awready = m.AWREADY & ~aw_done_q;
        o_wready  = m.WREADY & ~w_done_q;
      end
      WRESP: begin
        o_bvalid = m.BVALID;
        o_bresp  = m.BRESP;
        m.BREADY = g_bready;
      end
      READ: begin
        m.ARVALID = g_arvalid;
        o_arready = m.ARREADY;
      end
      RDATA: begin
        o_rvalid = m.RVALID;
        o_rdata  = m.RDATA;
        o_rresp  = m.RRESP;
        m.RREADY = g_rready;
      end
      default: ;
    endcase
  end

  always_comb begin
    s0.AWREADY = o_awready & ~g_q;
    s0.WREADY  = o_wready & ~g_q;
    s0.BVALID  = o_bvalid & ~g_q;
    s0.BRESP   = o_bresp & ~g_q;
    s0.ARREADY = o_arready & ~g_q;
    s0.RVALID  = o_rvalid & ~g_q;
    s0.RDATA   = g_q ? '0 : o_rdata;
    s0.RRESP   = o_rresp & ~g_q;
    s1.AWREADY = o_awready & g_q;
    s1.WREADY  = o_wready & g_q;
    s1.BVALID  = o_bvalid & g_q;
    s1.BRESP   = o_bresp & g_q;
    s1.ARREADY = o_arready & g_q;
    s1.RVALID  = o_rvalid & g_q;
    s1.RDATA   = g_q ? o_rdata : '0;
    s1.RRESP   = o_rresp & g_q;
  end

  assign busy  = (state_q != IDLE);
  assign grant = busy ? (g_q ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: tb/tb_axi4_lite_arb2.sv
// Bench for axi4_lite_arb2: two master agents, a memory slave model,
// per-master expected-response queues and a protocol monitor.
module tb_axi4_lite_arb2;
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  axi4_lite_if s0_if ();
  axi4_lite_if s1_if ();
  axi4_lite_if m_if ();
  logic [1:0] grant;
  logic       busy;

  axi4_lite_arb2 #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s0(s0_if), .s1(s1_if), .m(m_if),
    .grant(grant), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        resp;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  logic [31:0] ref_mem [64];
  logic [31:0] slv_mem [64];
  int slv_mode = 2;

  function automatic void sb_push(input int i, input exp_t e);
    if (i == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endfunction

  function automatic exp_t sb_pop(input int i);
    exp_t e;
    e.data = '0;
    e.resp = 1'b0;
    if (i == 0) begin
      if (sb0.size() > 0) e = sb0.pop_front();
    end else if (sb1.size() > 0) begin
      e = sb1.pop_front();
    end
    return e;
  endfunction

  task automatic mwr(input int i, input logic [7:0] a,
                     input logic [31:0] d, input logic [3:0] st,
                     input int lead);
    virtual axi4_lite_if vm;
    exp_t e, p;
    int n, t_aw, t_w;
    bit awd, wd, bd;
    logic [31:0] mrg;
    if (i == 0) vm = s0_if;
    else vm = s1_if;
    mrg = ref_mem[a[7:2]];
    for (int b = 0; b < 4; b++)
      if (st[b]) mrg[8*b +: 8] = d[8*b +: 8];
    ref_mem[a[7:2]] = mrg;
    e.data = '0;
    e.resp = a[6];
    sb_push(i, e);
    t_aw = (lead > 0) ? lead : 0;
    t_w  = (lead < 0) ? -lead : 0;
    vm.AWADDR = {24'h0, a};
    vm.AWPROT = 3'(i);
    vm.WDATA  = d;
    vm.WSTRB  = st;
    awd = 0; wd = 0; n = 0;
    while (!(awd && wd) && n < 100) begin
      vm.AWVALID = !awd && (n >= t_aw);
      vm.WVALID  = !wd && (n >= t_w);
      @(negedge ACLK);
      if (vm.AWVALID && vm.AWREADY) awd = 1;
      if (vm.WVALID && vm.WREADY) wd = 1;
      @(posedge ACLK); #1;
      n++;
    end
    vm.AWVALID = 1'b0;
    vm.WVALID  = 1'b0;
    check("wr_addr_data_hs", {30'h0, awd, wd}, 32'h3);
    bd = 0; n = 0;
    while (!bd && n < 100) begin
      vm.BREADY = ($urandom_range(0, 3) != 0);
      @(negedge ACLK);
      if (vm.BVALID && vm.BREADY) begin
        bd = 1;
        p = sb_pop(i);
        check("bresp", {31'h0, vm.BRESP}, {31'h0, p.resp});
      end
      @(posedge ACLK); #1;
      n++;
    end
    vm.BREADY = 1'b0;
    if (!bd) void'(sb_pop(i));
    check("b_hs", {31'h0, bd}, 32'h1);
  endtask

  task automatic mrd(input int i, input logic [7:0] a);
    virtual axi4_lite_if vm;
    exp_t e, p;
    int n;
    bit ad, rd;
    if (i == 0) vm = s0_if;
    else vm = s1_if;
    e.data = ref_mem[a[7:2]];
    e.resp = a[6];
    sb_push(i, e);
    vm.ARADDR = {24'h0, a};
    vm.ARPROT = 3'(i);
    ad = 0; n = 0;
    while (!ad && n < 100) begin
      vm.ARVALID = 1'b1;
      @(negedge ACLK);
      if (vm.ARVALID && vm.ARREADY) ad = 1;
      @(posedge ACLK); #1;
      n++;
    end
    vm.ARVALID = 1'b0;
    check("ar_hs", {31'h0, ad}, 32'h1);
    rd = 0; n = 0;
    while (!rd && n < 100) begin
      vm.RREADY = ($urandom_range(0, 3) != 0);
      @(negedge ACLK);
      if (vm.RVALID && vm.RREADY) begin
        rd = 1;
        p = sb_pop(i);
        check("rdata", vm.RDATA, p.data);
        check("rresp", {31'h0, vm.RRESP}, {31'h0, p.resp});
      end
      @(posedge ACLK); #1;
      n++;
    end
    vm.RREADY = 1'b0;
    if (!rd) void'(sb_pop(i));
    check("r_hs", {31'h0, rd}, 32'h1);
  endtask

  function automatic bit rdy();
    if (slv_mode == 0) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  // memory slave on the shared port
  initial begin
    bit aw_h, w_h, b_h, ar_h, r_h;
    bit have_aw, have_w, have_ar;
    logic [31:0] aw_a, w_d, ar_a, mrg;
    logic [3:0]  w_s;
    have_aw = 0; have_w = 0; have_ar = 0;
    aw_a = '0; w_d = '0; ar_a = '0; w_s = '0;
    m_if.AWREADY = 0; m_if.WREADY = 0; m_if.BVALID = 0;
    m_if.BRESP = 0; m_if.ARREADY = 0; m_if.RVALID = 0;
    m_if.RDATA = '0; m_if.RRESP = 0;
    forever begin
      @(negedge ACLK);
      aw_h = m_if.AWVALID && m_if.AWREADY;
      w_h  = m_if.WVALID && m_if.WREADY;
      b_h  = m_if.BVALID && m_if.BREADY;
      ar_h = m_if.ARVALID && m_if.ARREADY;
      r_h  = m_if.RVALID && m_if.RREADY;
      if (aw_h) aw_a = m_if.AWADDR;
      if (w_h) begin w_d = m_if.WDATA; w_s = m_if.WSTRB; end
      if (ar_h) ar_a = m_if.ARADDR;
      @(posedge ACLK); #1;
      if (!ARESETn) begin
        have_aw = 0; have_w = 0; have_ar = 0;
        m_if.AWREADY = 0; m_if.WREADY = 0; m_if.BVALID = 0;
        m_if.BRESP = 0; m_if.ARREADY = 0; m_if.RVALID = 0;
        m_if.RDATA = '0; m_if.RRESP = 0;
      end else begin
        if (aw_h) have_aw = 1;
        if (w_h) have_w = 1;
        if (ar_h) have_ar = 1;
        if (b_h) m_if.BVALID = 0;
        if (r_h) m_if.RVALID = 0;
        if (have_aw && have_w && !m_if.BVALID) begin
          mrg = slv_mem[aw_a[7:2]];
          for (int b = 0; b < 4; b++)
            if (w_s[b]) mrg[8*b +: 8] = w_d[8*b +: 8];
          slv_mem[aw_a[7:2]] = mrg;
          m_if.BVALID = 1;
          m_if.BRESP  = aw_a[6];
          have_aw = 0;
          have_w  = 0;
        end
        if (have_ar && !m_if.RVALID) begin
          m_if.RVALID = 1;
          m_if.RDATA  = slv_mem[ar_a[7:2]];
          m_if.RRESP  = ar_a[6];
          have_ar = 0;
        end
        // mode 1: AWREADY held off until W has been taken
        m_if.AWREADY = !have_aw && ((slv_mode == 1) ? have_w : rdy());
        m_if.WREADY  = !have_w && rdy();
        m_if.ARREADY = !have_ar && !m_if.RVALID && rdy();
      end
    end
  end

  // protocol monitor
  int cyc = 0, aw_cnt = 0, w_cnt = 0, aw_cyc = 0, w_cyc = 0;
  int viol = 0, b2b = 0, max_wait = 0;
  int wait_n [2];
  logic [31:0] last_awaddr = '0, last_wdata = '0;
  logic [1:0]  aw_grant = '0, prev_g = '0;
  logic [1:0]  glog[$];
  bit          op_exp[$];

  initial begin
    bit awhs, arhs, oth;
    int o;
    wait_n[0] = 0;
    wait_n[1] = 0;
    forever begin
      @(negedge ACLK);
      cyc++;
      if (ARESETn) begin
        awhs = m_if.AWVALID && m_if.AWREADY;
        arhs = m_if.ARVALID && m_if.ARREADY;
        if (awhs) begin
          aw_cnt++; aw_cyc = cyc;
          last_awaddr = m_if.AWADDR; aw_grant = grant;
        end
        if (m_if.WVALID && m_if.WREADY) begin
          w_cnt++; w_cyc = cyc; last_wdata = m_if.WDATA;
        end
        if ((awhs || arhs) && op_exp.size() > 0)
          check("t4_op_is_write", {31'h0, awhs}, {31'h0, op_exp.pop_front()});
        if ((s0_if.AWREADY | s0_if.WREADY | s0_if.ARREADY |
             s0_if.BVALID | s0_if.RVALID) && !grant[0]) viol++;
        if ((s1_if.AWREADY | s1_if.WREADY | s1_if.ARREADY |
             s1_if.BVALID | s1_if.RVALID) && !grant[1]) viol++;
        if (prev_g != 0 && grant != 0 && grant != prev_g) b2b++;
        if (prev_g == 0 && grant != 0) begin
          glog.push_back(grant);
          o = grant[1] ? 1 : 0;
          oth = o ? (s0_if.AWVALID | s0_if.ARVALID)
                  : (s1_if.AWVALID | s1_if.ARVALID);
          wait_n[o] = 0;
          if (oth) begin
            wait_n[1-o]++;
            if (wait_n[1-o] > max_wait) max_wait = wait_n[1-o];
          end
        end
        prev_g = grant;
      end else begin
        prev_g = '0;
      end
    end
  end

  task automatic clr_masters();
    s0_if.AWVALID = 0; s0_if.WVALID = 0; s0_if.BREADY = 0;
    s0_if.ARVALID = 0; s0_if.RREADY = 0;
    s1_if.AWVALID = 0; s1_if.WVALID = 0; s1_if.BREADY = 0;
    s1_if.ARVALID = 0; s1_if.RREADY = 0;
  endtask

  task automatic do_reset();
    ARESETn = 0;
    clr_masters();
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1;
    @(posedge ACLK); #1;
  endtask

  task automatic rnd_master(input int i, input int n);
    logic [7:0] a;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
      a = 8'(i * 128 + $urandom_range(0, 31) * 4);
      if ($urandom_range(0, 1) == 1)
        mwr(i, a, $urandom, 4'($urandom_range(1, 15)),
            int'($urandom_range(0, 6)) - 3);
      else
        mrd(i, a);
    end
  endtask

  initial begin
    bit got, arh;
    logic [1:0] g0, g1;
    int a0, w0;
    for (int k = 0; k < 64; k++) begin
      ref_mem[k] = '0;
      slv_mem[k] = '0;
    end
    clr_masters();
    s0_if.AWADDR = '0; s0_if.AWPROT = '0; s0_if.WDATA = '0;
    s0_if.WSTRB = '0; s0_if.ARADDR = '0; s0_if.ARPROT = '0;
    s1_if.AWADDR = '0; s1_if.AWPROT = '0; s1_if.WDATA = '0;
    s1_if.WSTRB = '0; s1_if.ARADDR = '0; s1_if.ARPROT = '0;
    // requests during reset must be ignored
    s0_if.AWVALID = 1;
    s1_if.ARVALID = 1;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_grant", {30'h0, grant}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_m_valid_ready",
          {27'h0, m_if.AWVALID, m_if.WVALID, m_if.ARVALID,
           m_if.BREADY, m_if.RREADY}, 32'h0);
    check("rst_s_ready_valid",
          {22'h0, s0_if.AWREADY, s0_if.WREADY, s0_if.ARREADY,
           s0_if.BVALID, s0_if.RVALID, s1_if.AWREADY, s1_if.WREADY,
           s1_if.ARREADY, s1_if.BVALID, s1_if.RVALID}, 32'h0);
    clr_masters();
    ARESETn = 1;
    @(posedge ACLK); #1;

    // T1
    slv_mode = 2;
    mwr(0, 8'h10, 32'h0000_CAFE, 4'hF, 0);
    check("t1_awaddr", last_awaddr, 32'h10);
    check("t1_wdata", last_wdata, 32'hCAFE);
    check("t1_grant", {30'h0, aw_grant}, 32'h1);
    check("t1_aw_w_same_cycle", aw_cyc, w_cyc);
    check("t1_idle_after", {31'h0, busy}, 32'h0);

    // T2
    do_reset();
    glog.delete();
    fork
      mrd(0, 8'h04);
      mrd(1, 8'h84);
    join
    g0 = (glog.size() > 0) ? glog[0] : 2'b00;
    g1 = (glog.size() > 1) ? glog[1] : 2'b00;
    check("t2_first_grant", {30'h0, g0}, 32'h1);
    check("t2_second_grant", {30'h0, g1}, 32'h2);

    // T3
    slv_mode = 1;
    a0 = aw_cnt;
    w0 = w_cnt;
    mwr(1, 8'hC4, 32'h1234_5678, 4'hF, 2);
    check("t3_aw_count", aw_cnt - a0, 32'h1);
    check("t3_w_count", w_cnt - w0, 32'h1);
    check("t3_w_before_aw", {31'h0, w_cyc < aw_cyc}, 32'h1);
    mrd(1, 8'hC4);

    // T4
    do_reset();
    slv_mode = 2;
    ref_mem[8] = 32'h55;
    op_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
    s0_if.AWADDR = 32'h20; s0_if.WDATA = 32'h55; s0_if.WSTRB = 4'hF;
    s0_if.ARADDR = 32'h20;
    s0_if.AWVALID = 1; s0_if.WVALID = 1; s0_if.ARVALID = 1;
    s0_if.BREADY = 1; s0_if.RREADY = 1;
    for (int n = 0; n < 80 && op_exp.size() > 0; n++) begin
      @(posedge ACLK); #1;
    end
    check("t4_ops_left", op_exp.size(), 32'h0);
    op_exp.delete();
    do_reset();

    // T5
    s0_if.ARADDR = 32'h08;
    s0_if.ARVALID = 1;
    s0_if.RREADY = 0;
    got = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge ACLK);
      if (s0_if.RVALID) begin
        got = 1;
        break;
      end
      arh = s0_if.ARVALID && s0_if.ARREADY;
      @(posedge ACLK); #1;
      if (arh) s0_if.ARVALID = 0;
    end
    check("t5_rvalid_before_reset", {31'h0, got}, 32'h1);
    ARESETn = 0;
    #1;
    check("t5_rvalid_in_reset", {31'h0, s0_if.RVALID}, 32'h0);
    check("t5_busy_in_reset", {31'h0, busy}, 32'h0);
    check("t5_grant_in_reset", {30'h0, grant}, 32'h0);
    @(posedge ACLK); #1;
    clr_masters();
    ARESETn = 1;
    @(posedge ACLK); #1;
    mrd(0, 8'h08);
    mwr(1, 8'h88, 32'hA5A5_0F0F, 4'b0101, -1);
    mrd(1, 8'h88);

    // T6
    slv_mode = 0;
    max_wait = 0;
    wait_n[0] = 0;
    wait_n[1] = 0;
    fork
      rnd_master(0, 2000);
      rnd_master(1, 2000);
    join
    check("t6_starvation", {31'h0, max_wait <= 2}, 32'h1);
    check("no_ungranted_outputs", viol, 32'h0);
    check("idle_between_grants", b2b, 32'h0);
    check("sb0_drained", sb0.size(), 32'h0);
    check("sb1_drained", sb1.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
